// File: rtl/conv1d_cfu_pkg.sv
// Shared constants, CFU command codes and controller states for the conv1d CFU driver.
package conv1d_cfu_pkg;

  localparam int KERNEL_LENGTH      = 8;
  localparam int MAX_INPUT_CHANNELS = 128;
  localparam int BUF                = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
  localparam int ADDR_W             = $clog2(BUF);

  typedef enum logic [6:0] {
    CMD_NONE         = 7'd0,
    CMD_WR_INPUT     = 7'd1,
    CMD_WR_WEIGHT    = 7'd2,
    CMD_INPUT_OFFSET = 7'd3,
    CMD_DEPTH        = 7'd5,
    CMD_START        = 7'd6,
    CMD_READ_ACC     = 7'd7,
    CMD_START_X      = 7'd8,
    CMD_READ_DONE    = 7'd9
  } cfu_cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_LOAD_W,
    ST_ZERO_W,
    ST_LOAD_I,
    ST_START,
    ST_POLL_REQ,
    ST_POLL_CHK,
    ST_READ_REQ,
    ST_READ_CAP,
    ST_OUT
  } state_e;

endpackage

// File: rtl/conv1d_cfu_load_pipe.sv
// Streams len bytes from the source: one read per cycle, each returned byte
// becomes a CFU write one cycle later at the same address.
module conv1d_cfu_load_pipe
  import conv1d_cfu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
);

  logic [ADDR_W-1:0] last_addr;

  assign last_addr = ADDR_W'(len - (ADDR_W + 1)'(1));
  assign last      = wr_en && (wr_addr == last_addr);

  // The write stage is a plain copy of the read stage delayed by the source latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_rd   <= 1'b0;
      src_addr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
    end else begin
      wr_en   <= src_rd;
      wr_addr <= src_addr;
      if (start) begin
        src_rd   <= 1'b1;
        src_addr <= '0;
      end else if (src_rd) begin
        if (src_addr == last_addr) src_rd <= 1'b0;
        else                       src_addr <= src_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv1d_cfu_driver.sv
// Job-level initiator for the conv1d CFU: configure, load weights and inputs,
// start, poll for done and return the accumulator (or an error flag).
module conv1d_cfu_driver
  import conv1d_cfu_pkg::*;
#(
  parameter int POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_input_offset,
  input  logic [31:0] job_depth,
  input  logic [31:0] job_start_x,
  output logic        src_rd,
  output logic        src_sel,
  output logic [9:0]  src_addr,
  input  logic [7:0]  src_rdata,
  output logic        cfu_en,
  output logic [6:0]  cfu_cmd,
  output logic [31:0] cfu_inp0,
  output logic [31:0] cfu_inp1,
  input  logic [31:0] cfu_ret,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy
);

  state_e            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [7:0]        poll_cnt, poll_n;
  logic [31:0]       off_q, off_n, depth_q, depth_n, sx_q, sx_n;
  logic [ADDR_W:0]   len_q, len_n;
  cfu_cmd_e          cmd_q, cmd_n;
  logic              en_q, en_n, sel_q;
  logic [31:0]       inp0_q, inp0_n, inp1_q, inp1_n;
  logic              res_valid_n, res_err_n;
  logic [31:0]       res_data_n;
  logic              pipe_start, pipe_last, wr_en, job_legal;
  logic [ADDR_W-1:0] wr_addr;

  conv1d_cfu_load_pipe u_load_pipe (
    .clk      (clk),
    .reset    (reset),
    .start    (pipe_start),
    .len      (len_q),
    .src_rd   (src_rd),
    .src_addr (src_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .last     (pipe_last)
  );

  assign job_legal = (job_depth != 32'd0) && (job_depth <= 32'(MAX_INPUT_CHANNELS))
                     && (job_start_x < 32'(KERNEL_LENGTH));

  // Load writes bypass the command registers so returned bytes reach the CFU with no bubble.
  assign src_sel  = sel_q;
  assign cfu_en   = en_q | wr_en;
  assign cfu_cmd  = wr_en ? (sel_q ? CMD_WR_WEIGHT : CMD_WR_INPUT) : cmd_q;
  assign cfu_inp0 = wr_en ? 32'(wr_addr) : inp0_q;
  assign cfu_inp1 = wr_en ? 32'(src_rdata) : inp1_q;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    poll_n      = poll_cnt;
    off_n       = off_q;
    depth_n     = depth_q;
    sx_n        = sx_q;
    len_n       = len_q;
    res_valid_n = res_valid;
    res_data_n  = res_data;
    res_err_n   = res_err;
    pipe_start  = 1'b0;
    case (state)
      ST_IDLE: if (job_valid && job_ready) begin
        off_n   = job_input_offset;
        depth_n = job_depth;
        sx_n    = job_start_x;
        len_n   = (ADDR_W + 1)'(job_depth[7:0]) << $clog2(KERNEL_LENGTH);
        cnt_n   = '0;
        if (job_legal) state_n = ST_CFG;
        else begin
          state_n     = ST_OUT;
          res_valid_n = 1'b1;
          res_err_n   = 1'b1;
          res_data_n  = '0;
        end
      end
      ST_CFG: begin
        if (cnt == ADDR_W'(2)) begin
          state_n    = ST_LOAD_W;
          pipe_start = 1'b1;
        end else cnt_n = cnt + ADDR_W'(1);
      end
      // A full-size kernel already covers every weight slot, so no zero tail is needed.
      ST_LOAD_W: if (pipe_last) begin
        if (len_q[ADDR_W]) begin
          state_n    = ST_LOAD_I;
          pipe_start = 1'b1;
        end else begin
          state_n = ST_ZERO_W;
          cnt_n   = len_q[ADDR_W-1:0];
        end
      end
      ST_ZERO_W: begin
        if (cnt == ADDR_W'(BUF - 1)) begin
          state_n    = ST_LOAD_I;
          pipe_start = 1'b1;
        end else cnt_n = cnt + ADDR_W'(1);
      end
      ST_LOAD_I: if (pipe_last) state_n = ST_START;
      ST_START: begin
        state_n = ST_POLL_REQ;
        poll_n  = '0;
      end
      ST_POLL_REQ: state_n = ST_POLL_CHK;
      ST_POLL_CHK: begin
        if (cfu_ret[0]) state_n = ST_READ_REQ;
        else begin
          poll_n = poll_cnt + 8'd1;
          if (poll_cnt == 8'(POLL_LIMIT - 1)) begin
            state_n     = ST_OUT;
            res_valid_n = 1'b1;
            res_err_n   = 1'b1;
            res_data_n  = '0;
          end else state_n = ST_POLL_REQ;
        end
      end
      ST_READ_REQ: state_n = ST_READ_CAP;
      ST_READ_CAP: begin
        state_n     = ST_OUT;
        res_valid_n = 1'b1;
        res_err_n   = 1'b0;
        res_data_n  = cfu_ret;
      end
      ST_OUT: if (res_ready) begin
        state_n     = ST_IDLE;
        res_valid_n = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase

    // Command outputs are decoded from the next state so they line up with the state register.
    en_n   = 1'b0;
    cmd_n  = CMD_NONE;
    inp0_n = '0;
    inp1_n = '0;
    case (state_n)
      ST_CFG: begin
        en_n = 1'b1;
        case (cnt_n[1:0])
          2'd0:    begin cmd_n = CMD_INPUT_OFFSET; inp1_n = off_n;   end
          2'd1:    begin cmd_n = CMD_DEPTH;        inp1_n = depth_n; end
          default: begin cmd_n = CMD_START_X;      inp1_n = sx_n;    end
        endcase
      end
      ST_ZERO_W: begin
        en_n   = 1'b1;
        cmd_n  = CMD_WR_WEIGHT;
        inp0_n = 32'(cnt_n);
      end
      ST_START:    begin en_n = 1'b1; cmd_n = CMD_START;     end
      ST_POLL_REQ: begin en_n = 1'b1; cmd_n = CMD_READ_DONE; end
      ST_READ_REQ: begin en_n = 1'b1; cmd_n = CMD_READ_ACC;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      poll_cnt  <= '0;
      off_q     <= '0;
      depth_q   <= '0;
      sx_q      <= '0;
      len_q     <= '0;
      cmd_q     <= CMD_NONE;
      en_q      <= 1'b0;
      inp0_q    <= '0;
      inp1_q    <= '0;
      sel_q     <= 1'b0;
      job_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      poll_cnt  <= poll_n;
      off_q     <= off_n;
      depth_q   <= depth_n;
      sx_q      <= sx_n;
      len_q     <= len_n;
      cmd_q     <= cmd_n;
      en_q      <= en_n;
      inp0_q    <= inp0_n;
      inp1_q    <= inp1_n;
      sel_q     <= (state_n == ST_LOAD_W);
      job_ready <= (state_n == ST_IDLE);
      busy      <= (state_n != ST_IDLE);
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      res_err   <= res_err_n;
    end
  end

endmodule
